// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD / CPU memory arbiter.
//   ADDR_W_DEF, DATA_W_DEF : default word-address and RGB565 data widths
//   STARVE_LIMIT_DEF       : default CPU wait, in cycles, before a forced grant
//   MISS_CNT_W             : width of the saturating dropped-LCD-request counter
//   arb_state_t            : arbiter FSM state encoding
package lcd_pkg;

    localparam int ADDR_W_DEF       = 11;
    localparam int DATA_W_DEF       = 16;
    localparam int STARVE_LIMIT_DEF = 32;
    localparam int MISS_CNT_W       = 16;

    // ST_IDLE    : CPU may be granted
    // ST_CPU_RSP : cycle in which cpu_ack is asserted
    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_CPU_RSP = 1'b1
    } arb_state_t;

endpackage

// File: rtl/lcd_mem_arbiter_if.sv
// Bus bundle between the arbiter, its two requesters and the single-port RAM.
//   lcd_* : LCD scan read port (request + one-cycle-later read data, miss report)
//   cpu_* : CPU request/acknowledge port
//   mem_* : synchronous single-port RAM port (one-cycle read latency)
// Modports: slave = arbiter view, master = environment (requesters + RAM) view.
//
// Handshakes:
//   CPU: cpu_req is raised with cpu_we/cpu_addr/cpu_wdata stable and held until
//        cpu_ack. cpu_ack is a one-cycle pulse one cycle after the grant;
//        cpu_rdata is valid only while cpu_ack is high (0 for writes).
//   LCD: fire-and-forget. lcd_req asks for one word in that cycle; if granted,
//        lcd_rvalid/lcd_rdata follow one cycle later, otherwise lcd_miss pulses
//        in the same cycle and the word is lost.
interface lcd_mem_arbiter_if #(
    parameter int ADDR_W = lcd_pkg::ADDR_W_DEF,
    parameter int DATA_W = lcd_pkg::DATA_W_DEF
);
    logic                          lcd_req;
    logic [ADDR_W-1:0]             lcd_addr;
    logic                          lcd_rvalid;
    logic [DATA_W-1:0]             lcd_rdata;
    logic                          lcd_miss;
    logic [lcd_pkg::MISS_CNT_W-1:0] lcd_miss_cnt;

    logic                          cpu_req;
    logic                          cpu_we;
    logic [ADDR_W-1:0]             cpu_addr;
    logic [DATA_W-1:0]             cpu_wdata;
    logic                          cpu_ack;
    logic [DATA_W-1:0]             cpu_rdata;

    logic                          mem_en;
    logic                          mem_we;
    logic [ADDR_W-1:0]             mem_addr;
    logic [DATA_W-1:0]             mem_wdata;
    logic [DATA_W-1:0]             mem_rdata;

    modport slave (
        input  lcd_req, lcd_addr,
        output lcd_rvalid, lcd_rdata, lcd_miss, lcd_miss_cnt,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output lcd_req, lcd_addr,
        input  lcd_rvalid, lcd_rdata, lcd_miss, lcd_miss_cnt,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/lcd_arb_starve_cnt.sv
// CPU starvation wait counter, used only when LCDARB_STARVE_GUARD_EN is defined.
// Counts cycles in which the CPU waits; clears on a CPU grant; saturates at
// STARVE_LIMIT. 'starved' is high once the limit has been reached.
//   clk, reset : pixel clock, asynchronous active-high reset
//   inc        : CPU waited this cycle (request high, IDLE, not granted)
//   clr        : CPU granted this cycle
//   starved    : counter has reached STARVE_LIMIT
module lcd_arb_starve_cnt #(
    parameter int STARVE_LIMIT = lcd_pkg::STARVE_LIMIT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic starved
);

    localparam int               CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != LIMIT)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign starved = (cnt_q == LIMIT);

endmodule

// File: rtl/lcd_mem_arbiter.sv
// Arbiter sharing one synchronous single-port RGB565 frame RAM between the LCD
// scan-out reader and the CPU. LCD has priority; the CPU is served in gaps.
// Optional macro LCDARB_STARVE_GUARD_EN adds a starvation guard: after the CPU
// has waited STARVE_LIMIT cycles it is granted over the LCD, the LCD word of
// that cycle is dropped and reported on lcd_miss / lcd_miss_cnt.
//   clk       : pixel clock, all logic on the rising edge
//   reset     : asynchronous active-high reset
//   bus       : lcd_mem_arbiter_if.slave (LCD, CPU and RAM ports)
//   dbg_state : current FSM state
module lcd_mem_arbiter
    import lcd_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                clk,
    input  logic                reset,
    lcd_mem_arbiter_if.slave    bus,
    output arb_state_t          dbg_state
);

    arb_state_t state_q, state_d;
    logic       lcd_grant;
    logic       cpu_grant;
    logic       force_cpu;
    logic       lcd_rvalid_q;
    logic       cpu_we_q;

`ifdef LCDARB_STARVE_GUARD_EN
    logic                  starved;
    logic [MISS_CNT_W-1:0] miss_cnt_q;

    lcd_arb_starve_cnt #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc     (bus.cpu_req && (state_q == ST_IDLE) && !cpu_grant),
        .clr     (cpu_grant),
        .starved (starved)
    );

    // A forced grant only makes sense in IDLE with a pending request.
    assign force_cpu = starved && (state_q == ST_IDLE) && bus.cpu_req;

    assign bus.lcd_miss = bus.lcd_req && !lcd_grant && !reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            miss_cnt_q <= '0;
        end else if (bus.lcd_miss && (miss_cnt_q != {MISS_CNT_W{1'b1}})) begin
            miss_cnt_q <= miss_cnt_q + 1'b1;
        end
    end

    assign bus.lcd_miss_cnt = miss_cnt_q;
`else
    // Strict LCD priority: the LCD is never refused, so nothing is ever missed.
    logic unused_starve_cfg;
    assign unused_starve_cfg = (STARVE_LIMIT != 0);
    assign force_cpu         = 1'b0;
    assign bus.lcd_miss      = 1'b0;
    assign bus.lcd_miss_cnt  = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant decode, next state and RAM port. Grants are suppressed while reset
    // is high so the RAM is never touched during reset.
    always_comb begin
        state_d       = state_q;
        cpu_grant     = 1'b0;
        lcd_grant     = 1'b0;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = ADDR_W'(0);
        bus.mem_wdata = DATA_W'(0);

        if (!reset) begin
            // CPU_RSP blocks the CPU so a still-high request is not served twice.
            cpu_grant = bus.cpu_req && (state_q == ST_IDLE) && (!bus.lcd_req || force_cpu);
            lcd_grant = bus.lcd_req && !cpu_grant;
        end

        case (state_q)
            ST_IDLE:    if (cpu_grant) state_d = ST_CPU_RSP;
            ST_CPU_RSP: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase

        if (cpu_grant) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = bus.cpu_we;
            bus.mem_addr  = bus.cpu_addr;
            bus.mem_wdata = bus.cpu_wdata;
        end else if (lcd_grant) begin
            bus.mem_en    = 1'b1;
            bus.mem_addr  = bus.lcd_addr;
        end
    end

    // Response bookkeeping: remember who owns next cycle's RAM read data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lcd_rvalid_q <= 1'b0;
            cpu_we_q     <= 1'b0;
        end else begin
            lcd_rvalid_q <= lcd_grant;
            if (cpu_grant) begin
                cpu_we_q <= bus.cpu_we;
            end
        end
    end

    assign bus.lcd_rvalid = lcd_rvalid_q;
    assign bus.lcd_rdata  = lcd_rvalid_q ? bus.mem_rdata : DATA_W'(0);
    assign bus.cpu_ack    = (state_q == ST_CPU_RSP);
    assign bus.cpu_rdata  = ((state_q == ST_CPU_RSP) && !cpu_we_q) ? bus.mem_rdata : DATA_W'(0);
    assign dbg_state      = state_q;

endmodule

// File: doc/lcd_mem_arbiter.md
LCD_MEM_ARBITER -- requirements
Module: lcd_mem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 11, memory word address width; DATA_W, default 16, RGB565 word width; STARVE_LIMIT, default 32, maximum CPU wait in cycles before a forced grant.
REQ-002 clk  input  1  pixel clock; all logic on rising edge.
REQ-003 reset  input  1  asynchronous active-high reset.
REQ-004 lcd_req  input  1  LCD scan read request, one word per cycle.
REQ-005 lcd_addr  input  ADDR_W  LCD read address.
REQ-006 lcd_rvalid  output  1  lcd_rdata valid.
REQ-007 lcd_rdata  output  DATA_W  LCD read data.
REQ-008 lcd_miss  output  1  one-cycle pulse when an LCD request is dropped.
REQ-009 lcd_miss_cnt  output  16  saturating count of dropped LCD requests.
REQ-010 cpu_req  input  1  CPU access request, held until cpu_ack.
REQ-011 cpu_we  input  1  1 = write, 0 = read.
REQ-012 cpu_addr / cpu_wdata  input  ADDR_W / DATA_W  CPU address and write data, stable while cpu_req is high.
REQ-013 cpu_ack  output  1  one-cycle completion pulse.
REQ-014 cpu_rdata  output  DATA_W  read data, valid while cpu_ack is high.
REQ-015 mem_en, mem_we  output  1  single-port synchronous RAM enable and write strobe.
REQ-016 mem_addr / mem_wdata  output  ADDR_W / DATA_W  RAM address and write data.
REQ-017 mem_rdata  input  DATA_W  RAM read data, one-cycle latency.

Function
REQ-018 Each cycle the block SHALL grant at most one requester: LCD, CPU, or none. Grant decode and mem_* outputs SHALL be combinational from the current-cycle inputs and state.
REQ-019 Priority SHALL be LCD over CPU, except when a forced CPU grant applies (REQ-026).
REQ-020 An LCD grant in cycle N SHALL drive lcd_rvalid=1 in cycle N+1, with lcd_rdata=mem_rdata.
REQ-021 A CPU grant in cycle N SHALL drive cpu_ack=1 in cycle N+1.
- cpu_rdata SHALL equal mem_rdata for a read.
- cpu_rdata SHALL be 0 for a write.
REQ-022 The FSM SHALL have two states:
- IDLE: CPU may be granted.
- CPU_RSP: the cycle in which cpu_ack is asserted.
REQ-023 Transitions:
- IDLE->CPU_RSP on a CPU grant.
- CPU_RSP->IDLE unconditionally.
REQ-024 In CPU_RSP, cpu_req SHALL NOT be granted, so a still-high request is not served twice; LCD may be granted in CPU_RSP.
REQ-025 An ungranted cpu_req SHALL stall with no side effects. cpu_addr, cpu_we and cpu_wdata SHALL be sampled only in the grant cycle.
REQ-026 Forced CPU grant (REQ-037 only): the wait counter counts cycles in which cpu_req is high in IDLE and ungranted. When it reaches STARVE_LIMIT, the next IDLE cycle SHALL grant CPU even if lcd_req=1.
REQ-027 An lcd_req that is not granted SHALL pulse lcd_miss in the same cycle and increment lcd_miss_cnt, which saturates at 16'hFFFF.
REQ-028 The wait counter SHALL clear on a CPU grant and saturate at STARVE_LIMIT.
REQ-029 When lcd_req=0 and there is no CPU grant, mem_en SHALL be 0 and mem_addr/mem_wdata SHALL hold 0.

Reset
REQ-030 While reset=1, and asynchronously on its assertion, the block SHALL enter IDLE.
REQ-031 Reset values: lcd_rvalid=0, lcd_rdata=0, cpu_ack=0, cpu_rdata=0, lcd_miss=0, lcd_miss_cnt=0, wait counter=0.
REQ-032 While reset=1, mem_en and mem_we SHALL be 0.
REQ-033 Reset during CPU_RSP SHALL suppress cpu_ack; the CPU re-issues its request.
REQ-034 Reset during an LCD read SHALL suppress lcd_rvalid.

Configuration
REQ-035 The macro LCDARB_STARVE_GUARD_EN SHALL select the starvation-guard feature.
REQ-036 Without the macro: strict LCD priority, lcd_miss and lcd_miss_cnt tied to 0, and no wait counter logic.
REQ-037 With the macro: REQ-026 to REQ-028 apply.

Structure
REQ-038 The shared package lcd_pkg SHALL hold ADDR_W/DATA_W defaults, the FSM state encoding and the STARVE_LIMIT default.
REQ-039 The wait counter SHALL be one sub-module, lcd_arb_starve_cnt, instantiated only under the macro.

Verification
REQ-040 CPU write 0x0005 <- 16'hF800 with lcd_req=0 -> mem_en=mem_we=1, addr 0x005 in cycle N; cpu_ack=1 in N+1.
REQ-041 CPU read 0x0005 with no contention -> cpu_ack at N+1, cpu_rdata=16'hF800.
REQ-042 lcd_req high for 480 cycles, addr 0..479, with cpu_req asserted at cycle 10, macro off -> all 480 lcd_rvalid, no misses, cpu_ack one cycle after lcd_req falls.
REQ-043 Same stimulus, macro on, STARVE_LIMIT=32 -> CPU forced grant at cycle 42, lcd_miss pulses once, lcd_miss_cnt=1, cpu_ack at 43.
REQ-044 cpu_req held high for 3 cycles after cpu_ack -> exactly one access per grant, no duplicate ack in the CPU_RSP cycle.
REQ-045 reset asserted in the CPU_RSP cycle -> cpu_ack=0, state IDLE; after release the re-issued request completes normally.
